// File: rtl/noun_traversal_engine_if.sv
// Memory and visitor handshake bundle between the traversal engine (master)
// and the memory arbiter / visitor unit (slave).
interface noun_traversal_engine_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              visit_req;
  logic [ADDR_W-1:0] visit_addr;
  logic [DATA_W-1:0] visit_data;
  logic              visit_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata,
    output visit_req, visit_addr, visit_data,
    input  visit_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata,
    input  visit_req, visit_addr, visit_data,
    output visit_ack
  );
endinterface

// File: rtl/noun_traversal_engine.sv
// Stackless pointer-reversal walker over {tag,hed,tel} noun cells; hands each
// completed cell to a visitor in post-order and restores memory on the way out.
module noun_traversal_engine #(
  parameter int ADDR_W    = 10,
  parameter int NOUN_W    = 28,
  parameter int TAG_W     = 8,
  parameter int EXEC_BIT  = 7,
  parameter int VISIT_ALL = 0,
  parameter int MAX_STEPS = 4096,
  localparam int DATA_W   = TAG_W + 2*NOUN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        error_o,
  output logic [15:0]       step_count_o,
  noun_traversal_engine_if.master bus
);
  localparam logic [3:0] S_IDLE = 4'd0,  S_RDRQ = 4'd1, S_RDWT = 4'd2, S_RESTORE = 4'd3,
                         S_DECIDE = 4'd4, S_WRRQ = 4'd5, S_WRWT = 4'd6, S_VISIT = 4'd7,
                         S_POP = 4'd8,  S_DONE = 4'd9, S_ERR = 4'd10;
  localparam logic [ADDR_W-1:0] NIL   = '1;
  localparam logic [31:0]       MAX_S = 32'(MAX_STEPS);

  typedef struct packed {
    logic [3:0]        st;
    logic [ADDR_W-1:0] c, b, child, nxt;
    logic              popped, desc;
    logic [TAG_W-1:0]  tag;
    logic [NOUN_W-1:0] hed, tel;
    logic [15:0]       step;
    logic [1:0]        err;
    logic              mreq, mwe, vreq;
    logic [ADDR_W-1:0] maddr;
    logic [DATA_W-1:0] mwdata;
  } regs_t;

  regs_t r_q, r_d;
  logic [15:0]       step_inc;
  logic              wd_hit, busy, fin_visit;
  logic [ADDR_W-1:0] hptr, tptr;
  logic [3:0]        fin_st;

  assign busy      = !(r_q.st == S_IDLE || r_q.st == S_DONE || r_q.st == S_ERR);
  assign step_inc  = (r_q.step == 16'hFFFF) ? r_q.step : r_q.step + 16'd1;
  assign wd_hit    = (MAX_S != 32'd0) && ({16'd0, step_inc} >= MAX_S);
  assign hptr      = r_q.hed[ADDR_W-1:0];
  assign tptr      = r_q.tel[ADDR_W-1:0];
  assign fin_visit = (VISIT_ALL != 0) || r_q.tag[EXEC_BIT];
  assign fin_st    = fin_visit ? S_VISIT : S_POP;

  always_comb begin
    r_d = r_q;
    case (r_q.st)
      S_IDLE, S_DONE, S_ERR: if (start_i && !abort_i) begin
        r_d.c      = start_addr_i;
        r_d.b      = NIL;
        r_d.popped = 1'b0;
        r_d.err    = 2'b00;
        r_d.step   = 16'd0;
        r_d.st     = (start_addr_i == NIL) ? S_DONE : S_RDRQ;
      end
      S_RDRQ: begin
        r_d.mreq  = 1'b1;
        r_d.mwe   = 1'b0;
        r_d.maddr = r_q.c;
        r_d.st    = S_RDWT;
      end
      S_RDWT: if (bus.mem_ready) begin
        r_d.mreq = 1'b0;
        r_d.step = step_inc;
        {r_d.tag, r_d.hed, r_d.tel} = bus.mem_rdata;
        if (wd_hit) begin r_d.st = S_ERR; r_d.err = 2'b01; end
        else        r_d.st = r_q.popped ? S_RESTORE : S_DECIDE;
      end
      // The field flagged as last descended holds our parent; put the child back.
      S_RESTORE: begin
        if (r_q.tag[2]) begin r_d.b = tptr; r_d.tel[ADDR_W-1:0] = r_q.child; end
        else            begin r_d.b = hptr; r_d.hed[ADDR_W-1:0] = r_q.child; end
        r_d.st = S_DECIDE;
      end
      S_DECIDE: begin
        if (!r_q.tag[1] && !r_q.tag[3]) begin
          if (hptr == NIL) begin r_d.st = S_ERR; r_d.err = 2'b10; end
          else begin
            r_d.tag[3] = 1'b1; r_d.hed[ADDR_W-1:0] = r_q.b;
            r_d.nxt = hptr; r_d.desc = 1'b1; r_d.st = S_WRRQ;
          end
        end else if (!r_q.tag[0] && !r_q.tag[2]) begin
          if (tptr == NIL) begin r_d.st = S_ERR; r_d.err = 2'b10; end
          else begin
            r_d.tag[2] = 1'b1; r_d.tel[ADDR_W-1:0] = r_q.b;
            r_d.nxt = tptr; r_d.desc = 1'b1; r_d.st = S_WRRQ;
          end
        end else begin
          r_d.tag[3] = 1'b0; r_d.tag[2] = 1'b0; r_d.desc = 1'b0;
          r_d.st = (!r_q.popped && !r_q.tag[3] && !r_q.tag[2]) ? fin_st : S_WRRQ;
        end
      end
      S_WRRQ: begin
        r_d.mreq   = 1'b1;
        r_d.mwe    = 1'b1;
        r_d.maddr  = r_q.c;
        r_d.mwdata = {r_q.tag, r_q.hed, r_q.tel};
        r_d.st     = S_WRWT;
      end
      S_WRWT: if (bus.mem_ready) begin
        r_d.mreq = 1'b0;
        r_d.mwe  = 1'b0;
        r_d.step = step_inc;
        if (wd_hit) begin r_d.st = S_ERR; r_d.err = 2'b01; end
        else if (r_q.desc) begin
          r_d.b = r_q.c; r_d.c = r_q.nxt; r_d.popped = 1'b0; r_d.st = S_RDRQ;
        end else r_d.st = fin_st;
      end
      S_VISIT: begin
        if (!r_q.vreq) r_d.vreq = 1'b1;
        else if (bus.visit_ack) begin r_d.vreq = 1'b0; r_d.st = S_POP; end
      end
      S_POP: begin
        if (r_q.b == NIL) r_d.st = S_DONE;
        else begin
          r_d.child = r_q.c; r_d.c = r_q.b; r_d.popped = 1'b1; r_d.st = S_RDRQ;
        end
      end
      default: r_d.st = S_IDLE;
    endcase
    // Abort leaves memory as-is; any reversed pointers are the caller's problem.
    if (abort_i && busy) begin
      r_d.st   = S_IDLE;
      r_d.mreq = 1'b0;
      r_d.mwe  = 1'b0;
      r_d.vreq = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      r_q.b <= NIL;
    end else begin
      r_q <= r_d;
    end
  end

  assign busy_o         = busy;
  assign done_o         = (r_q.st == S_DONE) || (r_q.st == S_ERR);
  assign error_o        = r_q.err;
  assign step_count_o   = r_q.step;
  assign bus.mem_req    = r_q.mreq;
  assign bus.mem_we     = r_q.mwe;
  assign bus.mem_addr   = r_q.maddr;
  assign bus.mem_wdata  = r_q.mwdata;
  assign bus.visit_req  = r_q.vreq;
  assign bus.visit_addr = r_q.vreq ? r_q.c : '0;
  assign bus.visit_data = r_q.vreq ? {r_q.tag, r_q.hed, r_q.tel} : '0;
endmodule

// File: tb/tb_noun_traversal_engine.sv
// Three engine instances (default, VISIT_ALL=1, MAX_STEPS=4) share one memory
// model and visitor responder; expected visits are queued and popped on visit_req.
module tb_noun_traversal_engine;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int sel = 0, stall_max = 0, n_rd = 0, n_wr = 0, n_vis = 0, stab_viol = 0;
  logic start = 1'b0, abort = 1'b0, vis_hold = 1'b0;
  logic [9:0] start_addr = '0;
  logic [2:0] busy, done;
  logic [1:0] err [3];
  logic [15:0] stp [3];

  logic [63:0] mem [1024];
  logic [63:0] gold [1024];
  logic [73:0] vq [$];

  logic m_req, m_we, v_req, m_ready = 1'b0, v_ack = 1'b0;
  logic [9:0] m_addr, v_addr;
  logic [63:0] m_wdata, v_data, m_rdata = '0;

  noun_traversal_engine_if #(.ADDR_W(10), .DATA_W(64)) b0 ();
  noun_traversal_engine_if #(.ADDR_W(10), .DATA_W(64)) b1 ();
  noun_traversal_engine_if #(.ADDR_W(10), .DATA_W(64)) b2 ();

  noun_traversal_engine u0 (.clk(clk), .rst_n(rst_n), .start_i(start && sel == 0), .start_addr_i(start_addr),
    .abort_i(abort && sel == 0), .busy_o(busy[0]), .done_o(done[0]), .error_o(err[0]), .step_count_o(stp[0]), .bus(b0));
  noun_traversal_engine #(.VISIT_ALL(1)) u1 (.clk(clk), .rst_n(rst_n), .start_i(start && sel == 1), .start_addr_i(start_addr),
    .abort_i(abort && sel == 1), .busy_o(busy[1]), .done_o(done[1]), .error_o(err[1]), .step_count_o(stp[1]), .bus(b1));
  noun_traversal_engine #(.MAX_STEPS(4)) u2 (.clk(clk), .rst_n(rst_n), .start_i(start && sel == 2), .start_addr_i(start_addr),
    .abort_i(abort && sel == 2), .busy_o(busy[2]), .done_o(done[2]), .error_o(err[2]), .step_count_o(stp[2]), .bus(b2));

  always_comb begin
    {m_req, m_we, m_addr, m_wdata, v_req, v_addr, v_data} = {b0.mem_req, b0.mem_we, b0.mem_addr, b0.mem_wdata,
                                                             b0.visit_req, b0.visit_addr, b0.visit_data};
    if (sel == 1) {m_req, m_we, m_addr, m_wdata, v_req, v_addr, v_data} = {b1.mem_req, b1.mem_we, b1.mem_addr,
                                                             b1.mem_wdata, b1.visit_req, b1.visit_addr, b1.visit_data};
    if (sel == 2) {m_req, m_we, m_addr, m_wdata, v_req, v_addr, v_data} = {b2.mem_req, b2.mem_we, b2.mem_addr,
                                                             b2.mem_wdata, b2.visit_req, b2.visit_addr, b2.visit_data};
  end
  assign b0.mem_ready = m_ready && sel == 0;
  assign b1.mem_ready = m_ready && sel == 1;
  assign b2.mem_ready = m_ready && sel == 2;
  assign b0.mem_rdata = m_rdata;
  assign b1.mem_rdata = m_rdata;
  assign b2.mem_rdata = m_rdata;
  assign b0.visit_ack = v_ack && sel == 0;
  assign b1.visit_ack = v_ack && sel == 1;
  assign b2.visit_ack = v_ack && sel == 2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: random wait, then a one-cycle ready; pending requests must hold still.
  int wcnt = 0;
  logic pend = 1'b0, p_we;
  logic [9:0] p_addr;
  logic [63:0] p_wd;
  always @(negedge clk) begin
    if (pend && (!m_req || m_addr !== p_addr || m_we !== p_we || m_wdata !== p_wd)) stab_viol++;
    pend = 1'b0;
    if (m_ready) m_ready = 1'b0;
    else if (m_req) begin
      if (wcnt == 0) begin
        if (m_we) begin mem[m_addr] = m_wdata; n_wr++; end
        else begin m_rdata = mem[m_addr]; n_rd++; end
        m_ready = 1'b1;
        wcnt = $urandom_range(0, stall_max);
      end else begin
        wcnt--;
        pend = 1'b1; p_addr = m_addr; p_we = m_we; p_wd = m_wdata;
      end
    end
  end

  int vdly = 0;
  logic [73:0] vexp;
  always @(negedge clk) begin
    if (v_ack) v_ack = 1'b0;
    else if (v_req && !vis_hold) begin
      if (vdly == 0) begin
        n_vis++;
        chk("visit_expected", 64'(vq.size() != 0), 64'd1);
        if (vq.size() != 0) begin
          vexp = vq.pop_front();
          chk("visit_addr", 64'(v_addr), 64'(vexp[73:64]));
          chk("visit_data", v_data, vexp[63:0]);
        end
        v_ack = 1'b1;
        vdly = $urandom_range(0, 3);
      end else vdly--;
    end
  end

  task automatic load_tree();
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0]  = {8'h00, 28'h5A00001, 28'h0C00002};
    mem[1]  = {8'h03, 28'h0000123, 28'h0000456};
    mem[2]  = {8'h83, 28'hABCDEF0, 28'h1234567};
    mem[5]  = {8'h03, 28'h00003FF, 28'h0000777};
    mem[10] = {8'h00, 28'h00003FF, 28'h0000001};
    for (int i = 0; i < 1024; i++) gold[i] = mem[i];
  endtask

  task automatic chk_image(input string tag);
    int diffs = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== gold[i]) diffs++;
    chk(tag, 64'(diffs), 64'd0);
  endtask

  task automatic run(input int k, input logic [9:0] root, output int cyc);
    n_rd = 0; n_wr = 0; n_vis = 0; stab_viol = 0;
    sel = k; start_addr = root; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 0;
    while (!done[k] && cyc < 3000) begin @(negedge clk); cyc++; end
    chk("walk_timeout", 64'(cyc < 3000), 64'd1);
  endtask

  int cyc;
  initial begin
    load_tree();
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err[0]), 64'd0);
    chk("rst_step", 64'(stp[0]), 64'd0);
    chk("rst_mreq", 64'({b0.mem_req, b1.mem_req, b2.mem_req}), 64'd0);
    chk("rst_vreq", 64'({b0.visit_req, b0.visit_addr, b0.visit_data}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run(0, 10'd5, cyc);
    chk("leaf_done", 64'(done[0]), 64'd1);
    chk("leaf_busy", 64'(busy[0]), 64'd0);
    chk("leaf_err", 64'(err[0]), 64'd0);
    chk("leaf_step", 64'(stp[0]), 64'd1);
    chk("leaf_rw", 64'({n_rd[7:0], n_wr[7:0]}), 64'h0100);
    chk("leaf_visits", 64'(n_vis), 64'd0);

    run(0, 10'h3FF, cyc);
    chk("nil_latency", 64'(cyc < 2), 64'd1);
    chk("nil_done", 64'(done[0]), 64'd1);
    chk("nil_step", 64'(stp[0]), 64'd0);
    chk("nil_noreq", 64'(n_rd + n_wr), 64'd0);

    // Root 0: read,write(hed) / read 1 / read,write(tel) / read 2 / read,write(final) = 8 transactions.
    vq.push_back({10'd2, gold[2]});
    run(0, 10'd0, cyc);
    chk("tree_err", 64'(err[0]), 64'd0);
    chk("tree_step", 64'(stp[0]), 64'd8);
    chk("tree_rw", 64'({n_rd[7:0], n_wr[7:0]}), 64'h0503);
    chk("tree_visits", 64'(n_vis), 64'd1);
    chk("tree_q_empty", 64'(vq.size()), 64'd0);
    chk_image("tree_image");

    stall_max = 5;
    vq.push_back({10'd2, gold[2]});
    run(0, 10'd0, cyc);
    chk("stall_err", 64'(err[0]), 64'd0);
    chk("stall_step", 64'(stp[0]), 64'd8);
    chk("stall_stable", 64'(stab_viol), 64'd0);
    chk("stall_visits", 64'(n_vis), 64'd1);
    chk_image("stall_image");
    stall_max = 2;

    vq.push_back({10'd1, gold[1]});
    vq.push_back({10'd2, gold[2]});
    vq.push_back({10'd0, gold[0]});
    run(1, 10'd0, cyc);
    chk("all_err", 64'(err[1]), 64'd0);
    chk("all_step", 64'(stp[1]), 64'd8);
    chk("all_visits", 64'(n_vis), 64'd3);
    chk("all_q_empty", 64'(vq.size()), 64'd0);
    chk_image("all_image");

    run(2, 10'd0, cyc);
    chk("wd_err", 64'(err[2]), 64'd1);
    chk("wd_step", 64'(stp[2]), 64'd4);
    chk("wd_done_busy", 64'({done[2], busy[2]}), 64'b10);
    load_tree();

    run(0, 10'd10, cyc);
    chk("nilptr_err", 64'(err[0]), 64'd2);
    chk("nilptr_done", 64'(done[0]), 64'd1);
    chk("nilptr_nowrite", 64'(n_wr), 64'd0);
    chk("nilptr_step", 64'(stp[0]), 64'd1);

    vis_hold = 1'b1; sel = 0; start_addr = 10'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 0;
    while (!v_req && cyc < 500) begin @(negedge clk); cyc++; end
    chk("abort_reach_visit", 64'(v_req), 64'd1);
    chk("abort_visit_addr", 64'(v_addr), 64'd2);
    chk("abort_visit_data", v_data, gold[2]);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_vreq", 64'(v_req), 64'd0);
    chk("abort_busy_done", 64'({busy[0], done[0]}), 64'd0);
    vis_hold = 1'b0;
    load_tree();
    vq.push_back({10'd2, gold[2]});
    run(0, 10'd0, cyc);
    chk("post_abort_err", 64'(err[0]), 64'd0);
    chk("post_abort_step", 64'(stp[0]), 64'd8);
    chk("post_abort_visits", 64'(n_vis), 64'd1);
    chk_image("post_abort_image");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
